// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM receive-side demultiplexer:
// the framing state encoding and the slot-index width helper.
package tdm_demux_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Width needed to hold the indices 0..n-1; at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdm_demux.sv
// TDM demultiplexer: collects CH slots per frame (slot 0 flagged by sync)
// and presents the whole frame on dout with a one-cycle frame_valid strobe.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 2
) (
  input  logic                   cp,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [W-1:0]           din,
  input  logic                   sync,
  output logic [CH*W-1:0]        dout,
  output logic                   frame_valid,
  output logic [clog2(CH)-1:0]   slot,
  output logic                   locked,
  output logic                   err
);

  localparam int             SW   = clog2(CH);
  localparam logic [SW-1:0]  LAST = SW'(CH - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_err;
  logic                    w_err_nxt;
  logic                    w_start;
  logic                    w_store;
  logic                    w_done;

  logic [CH-2:0][W-1:0]    r_shadow;
  logic [SW-1:0]           r_slot;
  logic [CH*W-1:0]         r_dout;
  logic                    r_frame_valid;

  // Any enabled sync restarts a frame; in LOCKED it is an error unless it lands on slot 0.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_done      = 1'b0;
    if (en) begin
      if (sync) begin
        w_start     = 1'b1;
        w_state_nxt = ST_LOCKED;
        if (r_state == ST_LOCKED && r_slot != '0) w_err_nxt = 1'b1;
      end else if (r_state == ST_LOCKED) begin
        if (r_slot == '0) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_HUNT;
        end else if (r_slot == LAST) begin
          w_done = 1'b1;
        end else begin
          w_store = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Shadow capture and slot counter; the final slot goes straight to dout without a shadow stage.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_slot        <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_done;
      if (w_start) begin
        r_shadow[0] <= din;
        r_slot      <= SW'(1);
      end
      for (int k = 1; k < CH - 1; k++) begin
        if (w_store && r_slot == SW'(k)) r_shadow[k] <= din;
      end
      if (w_store) r_slot <= r_slot + SW'(1);
      if (w_done) begin
        r_dout <= {din, r_shadow};
        r_slot <= '0;
      end
      if (en && !sync && r_state == ST_LOCKED && r_slot == '0) r_slot <= '0;
    end
  end

  assign dout        = r_dout;
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign locked      = (r_state == ST_LOCKED);
  assign err         = r_err;

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the registered channel mux.
- Takes one time-division-multiplexed stream, one slot per enabled clock, with a frame-start marker on slot 0.
- Splits the stream back into CH parallel channel words. A full frame is presented at once with a one-cycle valid strobe.
- Sits between the TDM link and the per-channel consumers.

Parameters:
CH, 4, number of slots per frame (>=2)
W, 2, data width of one slot

Ports:
cp  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  slot enable; din/sync sampled only when en=1
din  input  W  slot data
sync  input  1  frame marker, valid with en; marks slot 0
dout  output  CH*W  last complete frame; slot k at dout[k*W +: W]
frame_valid  output  1  one-cycle pulse: dout just updated
slot  output  clog2(CH)  index of next slot expected
locked  output  1  1 while in LOCKED state
err  output  1  one-cycle pulse on framing error

Behaviour:
- Interface: one clock, cp. Reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, any time, mid-frame included):
  - dout=0, frame_valid=0, err=0, slot=0, locked=0.
  - Shadow registers cleared; state=HUNT.
  - Deassertion takes effect from the next cp edge.
- en=0: all state, shadow and dout hold; frame_valid and err drop to 0.
- States: HUNT, LOCKED. All outputs are registered, with no combinational path from inputs to outputs.
- HUNT:
  - en=1, sync=0: ignore din.
  - en=1, sync=1: shadow[0]<=din, slot<=1, ->LOCKED.
- LOCKED, en=1, sync=0, slot=k with 0<k<CH-1: shadow[k]<=din, slot<=k+1.
- LOCKED, en=1, sync=0, slot=CH-1 (frame completes):
  - dout<={din, shadow[CH-2..0]}.
  - frame_valid<=1 for exactly one cycle; slot<=0.
- LOCKED, en=1, slot=0, sync=1: shadow[0]<=din, slot<=1.
- LOCKED, en=1, slot=0, sync=0 (missing marker):
  - err<=1, ->HUNT, slot<=0.
  - din discarded; dout holds.
- LOCKED, en=1, slot!=0, sync=1 (early marker):
  - err<=1; partial frame discarded; dout holds.
  - Treated as a new frame start: shadow[0]<=din, slot<=1; stays LOCKED.
- Latency: dout and frame_valid change on the same cp edge that samples the last slot.
- Back-to-back frames are supported (sync on the enabled cycle after the last slot), giving one frame_valid every CH enabled cycles.
- err and frame_valid are never both 1, since a slot CH-1 sample with sync=1 is an early-marker error.
- locked = (state==LOCKED).
- slot counter wraps CH-1 -> 0; it never holds values >= CH.

Decomposition:
- Shared package holds:
  - state encoding constants ST_HUNT=1'b0, ST_LOCKED=1'b1;
  - slot-index width function clog2.
- No sub-module needed.
- Shadow registers plus the slot counter are a single always block; FSM in a second block.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles -> dout=0, slot=0, locked=0, err=0, frame_valid=0; en=1, sync=0, din=3 for 5 cycles -> state unchanged.
- Normal frame (CH=4, W=2): en=1 continuously, sync=1 with din=1, then din=2,3,0 -> on 4th edge dout=8'b00_11_10_01, frame_valid=1 for one cycle, slot=0, locked=1.
- Gapped enable: same frame as above with en=0 for 2 cycles between each slot -> identical dout, frame_valid only on the last enabled slot, outputs frozen during gaps.
- Early sync: frame start din=1, then din=2, then sync=1 with din=3 at slot 2 -> err pulse; next slots din=1,2,0 -> dout=8'b00_10_01_11, no frame_valid for the aborted frame.
- Missing sync: complete one frame, then en=1, sync=0 at slot 0 -> err=1 one cycle, locked=0, dout retains previous frame; next sync=1 relocks.
- Async reset mid-frame: after 2 slots pull rst_n low between edges -> outputs 0 immediately without a cp edge; after release, a full frame is required before frame_valid.
